addseq_ctrl: RTL and testbench

//   Sequencer that computes one 8*NBYTES-bit add over NBYTES cycles through a

---
 rtl/addseq_ctrl.sv | 153 +++++++++++++++
 tb/tb_addseq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addseq_ctrl.sv
// Byte-serial wide adder: one 8-bit ripple-carry slice processes the
// operands LSB byte first. Optional subtract mode is enabled by ADDSEQ_SUB_EN.
module addseq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic            subIn;
    logic            subEff;
    logic [CW+2:0]   bitBase;
    logic [7:0]      byteA;
    logic [7:0]      byteB;
    logic [8:0]      byteRes;
    logic            msbCarryIn;

`ifdef ADDSEQ_SUB_EN
    logic sub_q, sub_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end

    assign subIn  = sub;
    assign subEff = sub_q;
    assign sub_d  = (state_q == IDLE && in_valid) ? sub : sub_q;
`else
    assign subIn  = 1'b0;
    assign subEff = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Subtraction reuses the adder by inverting B bytes; the carry-in
    // inversion is folded into the carry register when operands are captured.
    always_comb begin
        bitBase    = {cnt_q, 3'b000};
        byteA      = a_q[bitBase +: 8];
        byteB      = b_q[bitBase +: 8] ^ {8{subEff}};
        byteRes    = {1'b0, byteA} + {1'b0, byteB} + {8'd0, carry_q};
        msbCarryIn = byteA[7] ^ byteB[7] ^ byteRes[7];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin ^ subIn;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[bitBase +: 8] = byteRes[7:0];
                carry_d             = byteRes[8];
                if (cnt_q == CW'(NBYTES - 1)) begin
                    cout_d  = byteRes[8];
                    ovf_d   = msbCarryIn ^ byteRes[8];
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_addseq_ctrl.sv
// Self-checking bench for addseq_ctrl: a 4-byte instance driven through a
// scoreboard, plus a 1-byte instance run back-to-back with out_ready tied high.
module tb_addseq_ctrl;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } expT;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        cin1;
    logic        sub1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  sum1;
    logic        cout1;
    logic        ovf1;
    logic        busy1;

    expT sbQ[$];
    expT sb1Q[$];
    int  checkCount;
    int  passCount;

    addseq_ctrl #(.NBYTES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    addseq_ctrl #(.NBYTES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef ADDSEQ_SUB_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a + (sub ? ~b : b) + (sub ? ~cin : cin), overflow from sign rule.
    function automatic expT refAdd32(input logic [31:0] aV, input logic [31:0] bV,
                                     input logic cinV, input logic subV);
        expT         e;
        logic [31:0] bb;
        logic        cc;
        logic [32:0] full;
        bb     = subV ? ~bV : bV;
        cc     = subV ? ~cinV : cinV;
        full   = {1'b0, aV} + {1'b0, bb} + {32'd0, cc};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (aV[31] == bb[31]) && (full[31] != aV[31]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] aV, input logic [31:0] bV,
                                 input logic cinV, input logic subV);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("inReadyWait", {63'd0, in_ready}, 64'd1);
        a        = aV;
        b        = bV;
        cin      = cinV;
        sub      = subV;
        in_valid = 1'b1;
        sbQ.push_back(refAdd32(aV, bV, cinV, subV));
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~aV;
        b        = ~bV;
        cin      = ~cinV;
        sub      = ~subV;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("outValidWait", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic collectResult(input string tag);
        expT e;
        if (sbQ.size() == 0) begin
            checkOutput({tag, "SbEmpty"}, {63'd0, out_valid}, 64'd0);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, "Sum"},  {32'd0, sum},  {32'd0, e.sum});
            checkOutput({tag, "Cout"}, {63'd0, cout}, {63'd0, e.cout});
            checkOutput({tag, "Ovf"},  {63'd0, ovf},  {63'd0, e.ovf});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "InReadyAfter"},  {63'd0, in_ready},  64'd1);
        checkOutput({tag, "OutValidAfter"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int  cycles;
        int  results;
        int  opIdx;
        expT e1;

        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        sub1       = 1'b0;
        out_ready1 = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rstInReady",  {63'd0, in_ready},  64'd1);
        checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
        checkOutput("rstBusy",     {63'd0, busy},      64'd0);
        checkOutput("rstSum",      {32'd0, sum},       64'd0);
        checkOutput("rstCout",     {63'd0, cout},      64'd0);
        checkOutput("rstOvf",      {63'd0, ovf},       64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort mid-RUN after two byte cycles, then a clean add.
        applyStimulus(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("midRunBusy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortInReady",  {63'd0, in_ready},  64'd1);
        checkOutput("abortOutValid", {63'd0, out_valid}, 64'd0);
        checkOutput("abortSum",      {32'd0, sum},       64'd0);
        checkOutput("abortCout",     {63'd0, cout},      64'd0);
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h1000_0001, 32'h2000_0002, 1'b0, 1'b0);
        waitDone(cycles);
        collectResult("postAbort");

        // Inter-byte carry chain and exact latency.
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        waitDone(cycles);
        checkOutput("latency", 64'(cycles), 64'd4);
        collectResult("carryChain");

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        waitDone(cycles);
        collectResult("wrap");

        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        waitDone(cycles);
        collectResult("signedOvf");

        // Backpressure in DONE with ignored in_valid pulses.
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waitDone(cycles);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(negedge clk);
            checkOutput("holdSum",      {32'd0, sum},       {32'd0, sbQ[0].sum});
            checkOutput("holdCout",     {63'd0, cout},      {63'd0, sbQ[0].cout});
            checkOutput("holdInReady",  {63'd0, in_ready},  64'd0);
            checkOutput("holdOutValid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        collectResult("backpressure");
        repeat (3) begin
            @(negedge clk);
            checkOutput("noGhostBusy", {63'd0, busy}, 64'd0);
        end

`ifdef ADDSEQ_SUB_EN
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        waitDone(cycles);
        collectResult("subBorrow");
        applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        waitDone(cycles);
        collectResult("subNoBorrow");
`endif

        // Single-byte instance, back-to-back with out_ready tied high.
        results = 0;
        opIdx   = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (out_valid1) begin
                if (sb1Q.size() == 0) begin
                    checkOutput("nb1Spurious", {63'd0, out_valid1}, 64'd0);
                end else begin
                    e1 = sb1Q.pop_front();
                    checkOutput("nb1Sum",  {56'd0, sum1},  {56'd0, e1.sum[7:0]});
                    checkOutput("nb1Cout", {63'd0, cout1}, {63'd0, e1.cout});
                    checkOutput("nb1Ovf",  {63'd0, ovf1},  {63'd0, e1.ovf});
                    results++;
                end
            end
            if (in_ready1) begin
                if (opIdx == 0) begin
                    a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0;
                end else if (opIdx == 1) begin
                    a1 = 8'h7F; b1 = 8'h01; cin1 = 1'b0;
                end else begin
                    a1   = 8'($urandom_range(0, 255));
                    b1   = 8'($urandom_range(0, 255));
                    cin1 = 1'($urandom_range(0, 1));
                end
                sb1Q.push_back(refAdd32({{24{a1[7]}}, a1} << 24 >> 24 << 24,
                                        {b1, 24'd0}, 1'b0, 1'b0));
                e1.sum  = {24'd0, 8'({1'b0, a1} + {1'b0, b1} + {8'd0, cin1})};
                e1.cout = 1'(({1'b0, a1} + {1'b0, b1} + {8'd0, cin1}) >> 8);
                e1.ovf  = (a1[7] == b1[7]) && (e1.sum[7] != a1[7]);
                sb1Q[sb1Q.size() - 1] = e1;
                in_valid1 = 1'b1;
                opIdx++;
            end
        end
        in_valid1 = 1'b0;
        checkOutput("nb1Count", {63'd0, (results >= 8)}, 64'd1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
